i2c_target_rx: RTL and testbench

- I2C target (slave) receiver. It is the far end of the controller-side transmit data path (k_data1..k_data4, k_data_end).
- Oversamples the SCL/SDA bus on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit own address on write transfers, shifts in data bytes MSB first, and drives ACK/NACK on SDA.
- Hands each received byte to fabric logic as a one-cycle tick, gated by a ready handshake.

---
 rtl/i2c_target_rx_pkg.sv | 13 +
 rtl/i2c_line_sync.sv | 40 ++++
 rtl/i2c_target_rx.sv | 128 ++++++++++++
 tb/tb_i2c_target_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_rx_pkg.sv
// i2c_target_rx_pkg: state encodings and byte-framing constants for the I2C target receiver.
package i2c_target_rx_pkg;
  typedef enum logic [3:0] {
    k_idle     = 4'd0,
    k_addr     = 4'd1,
    k_addr_ack = 4'd2,
    k_data     = 4'd3,
    k_data_ack = 4'd4,
    k_ignore   = 4'd5
  } state_t;
  localparam logic       k_rw_write      = 1'b0;
  localparam logic [3:0] k_bits_per_byte = 4'd8;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: pin synchroniser, optional 3-sample glitch filter and edge detector.
// Filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise_tick,
  output logic fall_tick
);
  logic [SYNC_STAGES-1:0] sync;
  logic filt, prev;
  // Reset to 1 so an idle bus produces no edges when reset is released
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], pin};
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic maj;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hist <= '1;
      maj  <= 1'b1;
    end else begin
      hist <= {hist[0], sync[SYNC_STAGES-1]};
      maj  <= &{hist, sync[SYNC_STAGES-1]} ? 1'b1 : ~|{hist, sync[SYNC_STAGES-1]} ? 1'b0 : maj;
    end
  assign filt = maj;
`else
  assign filt = sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev <= 1'b1;
    else prev <= filt;
  assign level     = filt;
  assign rise_tick = filt & ~prev;
  assign fall_tick = ~filt & prev;
endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C write-only target; matches OWN_ADDR, receives bytes MSB first, drives ACK/NACK.
// Optional SCL/SDA glitch filter via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_rx
  import i2c_target_rx_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull_low_out,
  input  logic       rx_ready_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_tick_out,
  output logic       addressed_out,
  output logic       stop_tick_out,
  output logic       busy_out
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, addr_match;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic pull_q, pull_d, valid_q, valid_d, addr_q, addr_d, stop_q, stop_d, busy_q, busy_d;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .reset_n(reset_n), .pin(scl_in),
    .level(scl_lvl), .rise_tick(scl_rise), .fall_tick(scl_fall)
  );
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .reset_n(reset_n), .pin(sda_in),
    .level(sda_lvl), .rise_tick(sda_rise), .fall_tick(sda_fall)
  );

  // An SCL edge in the same cycle turns an SDA edge into ordinary data
  assign start      = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop       = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
  assign addr_match = (sh_q[7:1] == OWN_ADDR) && (sh_q[0] == k_rw_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pull_d  = pull_q;
    data_d  = data_q;
    valid_d = 1'b0;
    addr_d  = addr_q;
    stop_d  = 1'b0;
    busy_d  = busy_q;
    if (start) begin
      state_d = k_addr;
      cnt_d   = '0;
      addr_d  = 1'b0;
      pull_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (stop) begin
      state_d = k_idle;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
      stop_d  = addr_q;
      addr_d  = 1'b0;
    end else begin
      if ((state_q == k_addr || state_q == k_data) && scl_rise && cnt_q != k_bits_per_byte) begin
        sh_d  = {sh_q[6:0], sda_lvl};
        cnt_d = cnt_q + 4'd1;
      end
      if (scl_fall) begin
        case (state_q)
          k_addr: if (cnt_q == k_bits_per_byte) begin
            state_d = addr_match ? k_addr_ack : k_ignore;
            pull_d  = addr_match;
          end
          k_addr_ack: begin
            state_d = k_data;
            pull_d  = 1'b0;
            addr_d  = 1'b1;
            cnt_d   = '0;
          end
          k_data: if (cnt_q == k_bits_per_byte) begin
            state_d = rx_ready_in ? k_data_ack : k_ignore;
            pull_d  = rx_ready_in;
            valid_d = rx_ready_in;
            data_d  = rx_ready_in ? sh_q : data_q;
          end
          k_data_ack: begin
            state_d = k_data;
            pull_d  = 1'b0;
            cnt_d   = '0;
          end
          k_ignore: pull_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= k_idle;
      cnt_q   <= '0;
      sh_q    <= '0;
      pull_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pull_q  <= pull_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
    end

  assign sda_pull_low_out  = pull_q;
  assign rx_data_out       = data_q;
  assign rx_valid_tick_out = valid_q;
  assign addressed_out     = addr_q;
  assign stop_tick_out     = stop_q;
  assign busy_out          = busy_q;
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: bit-level I2C controller model driving the target, with a transaction-level reference.
module tb_i2c_target_rx;
  localparam logic [6:0] OWN = 7'h42;
  logic clk = 1'b0;
  logic reset_n, scl_in, sda_drv, sda_in, rx_ready_in;
  logic sda_pull_low_out, rx_valid_tick_out, addressed_out, stop_tick_out, busy_out;
  logic [7:0] rx_data_out;
  int errors = 0, checks = 0, stop_cnt = 0, exp_stops = 0, pull_viol = 0;
  logic [7:0] got_q[$], exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic [7:0] bytes[4];
  bit rdy[4];
  logic pull_prev = 1'b0;

  assign sda_in = sda_drv & ~sda_pull_low_out;
  always #5 clk = ~clk;

  i2c_target_rx #(.OWN_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_pull_low_out(sda_pull_low_out), .rx_ready_in(rx_ready_in),
    .rx_data_out(rx_data_out), .rx_valid_tick_out(rx_valid_tick_out),
    .addressed_out(addressed_out), .stop_tick_out(stop_tick_out), .busy_out(busy_out)
  );

  always @(negedge clk) begin
    if (rx_valid_tick_out) got_q.push_back(rx_data_out);
    if (stop_tick_out) stop_cnt++;
  end
  always @(negedge clk) begin
    if (reset_n && scl_in && sda_pull_low_out !== pull_prev) pull_viol++;
    pull_prev = sda_pull_low_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qw();
    repeat (8) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_drv = 1'b1; qw(); scl_in = 1'b1; qw(); sda_drv = 1'b0; qw(); scl_in = 1'b0; qw();
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0; qw(); scl_in = 1'b1; qw(); sda_drv = 1'b1; qw(); qw();
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; qw(); scl_in = 1'b1; qw(); qw(); scl_in = 1'b0; qw();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; qw(); scl_in = 1'b1; qw();
    ack = !sda_in;
    qw(); scl_in = 1'b0; qw();
  endtask

  task automatic compare_rx();
    check("rx_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("rx_byte", got_q[i], exp_q[i]);
    check("rx_data_hold", rx_data_out, last_data);
    check("stop_ticks", stop_cnt, exp_stops);
    got_q.delete();
    exp_q.delete();
  endtask

  // Reference: ACK the address only for OWN+write; each byte is ACKed and delivered
  // while every earlier byte was accepted and ready is high at its completion.
  task automatic xfer(input logic [6:0] a, input logic rw, input int n, input bit do_stop);
    bit ack, ok, acc;
    ok = (a == OWN) && (rw == 1'b0);
    start_cond();
    check("busy_start", busy_out, 1);
    check("addr_drop", addressed_out, 0);
    send_byte({a, rw}, ack);
    check("addr_ack", ack, ok);
    check("addressed", addressed_out, ok);
    acc = ok;
    for (int i = 0; i < n; i++) begin
      rx_ready_in = rdy[i];
      send_byte(bytes[i], ack);
      acc = acc && rdy[i];
      check("data_ack", ack, acc);
      if (acc) begin
        exp_q.push_back(bytes[i]);
        last_data = bytes[i];
      end
    end
    if (do_stop) begin
      check("busy_before_stop", busy_out, 1);
      stop_cond();
      if (ok) exp_stops++;
      check("addressed_after_stop", addressed_out, 0);
      check("busy_after_stop", busy_out, 0);
      compare_rx();
    end
  endtask

  initial begin
    bit ack;
    reset_n = 1'b0; scl_in = 1'b1; sda_drv = 1'b1; rx_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pull", sda_pull_low_out, 0);
    check("rst_data", rx_data_out, 0);
    check("rst_valid", rx_valid_tick_out, 0);
    check("rst_addressed", addressed_out, 0);
    check("rst_stop", stop_tick_out, 0);
    check("rst_busy", busy_out, 0);
    reset_n = 1'b1;
    qw();
    check("idle_busy", busy_out, 0);

    bytes[0] = 8'hA5; rdy[0] = 1;
    xfer(OWN, 1'b0, 1, 1);

    bytes[0] = 8'h3C; bytes[1] = 8'hC3; rdy[0] = 1; rdy[1] = 1;
    xfer(7'h43, 1'b0, 2, 1);

    bytes[0] = 8'h77; rdy[0] = 1;
    xfer(OWN, 1'b1, 1, 1);

    bytes[0] = 8'h01; bytes[1] = 8'h80; rdy[0] = 1; rdy[1] = 0;
    xfer(OWN, 1'b0, 2, 1);
    check("hold_01", rx_data_out, 8'h01);

    start_cond();
    send_byte({OWN, 1'b0}, ack);
    check("partial_addr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bytes[0] = 8'h5A; rdy[0] = 1;
    xfer(OWN, 1'b0, 1, 1);
    check("restart_data", rx_data_out, 8'h5A);

    for (int t = 0; t < 8; t++) begin
      logic [6:0] a;
      logic rw;
      int n;
      a  = $urandom_range(0, 1) ? OWN : 7'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        bytes[i] = 8'($urandom);
        rdy[i]   = ($urandom_range(0, 3) != 0);
      end
      xfer(a, rw, n, 1);
    end

    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : OWN[i-1]);
    check("ack_driven", sda_pull_low_out, 1);
    reset_n = 1'b0;
    #1;
    check("rst_ack_pull", sda_pull_low_out, 0);
    check("rst_ack_data", rx_data_out, 0);
    check("rst_ack_addressed", addressed_out, 0);
    check("rst_ack_busy", busy_out, 0);
    check("rst_ack_valid", rx_valid_tick_out, 0);
    last_data = 8'h00;
    sda_drv = 1'b1; qw(); scl_in = 1'b1; qw();
    reset_n = 1'b1;
    qw();
    bytes[0] = 8'($urandom); rdy[0] = 1;
    xfer(OWN, 1'b0, 1, 1);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    @(negedge clk) sda_drv = 1'b0;
    @(negedge clk) sda_drv = 1'b1;
    qw();
    check("glitch_busy", busy_out, 0);
`endif

    check("pull_while_scl_high", pull_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
